latch_rf_wr_sched: RTL and testbench



---
 rtl/latch_rf_pkg.sv | 5 +
 rtl/latch_rf_wr_sched_if.sv | 14 +
 rtl/latch_rf_rr_arb2.sv | 17 +
 rtl/latch_rf_wr_sched.sv | 63 ++++++
 tb/tb_latch_rf_wr_sched.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/latch_rf_pkg.sv
// latch_rf_pkg: shared state encoding and requester count for the latch RF write scheduler
package latch_rf_pkg;
  localparam int NREQ = 2;
  typedef enum logic [1:0] {RUN, DRAIN, SLEEP} state_t;
endpackage

// File: rtl/latch_rf_wr_sched_if.sv
// latch_rf_wr_sched_if: two-requester write request bundle (valid/address/data with ready)
interface latch_rf_wr_sched_if
  import latch_rf_pkg::*;
#(
  parameter int AW    = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_rdy;
  modport master (output req_vld, req_addr, req_data, input req_rdy);
  modport slave (input req_vld, req_addr, req_data, output req_rdy);
endinterface

// File: rtl/latch_rf_rr_arb2.sv
// latch_rf_rr_arb2: 2-way round-robin arbiter; pointer moves past the winner on each accept
module latch_rf_rr_arb2
  import latch_rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic [NREQ-1:0] vld,
  input  logic            en,
  input  logic            accept,
  output logic [NREQ-1:0] grant
);
  logic ptr;
  always_comb grant = !en ? '0 : &vld ? (ptr ? 2'b10 : 2'b01) : vld;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) ptr <= 1'b0;
    else if (accept) ptr <= grant[0];
endmodule

// File: rtl/latch_rf_wr_sched.sv
// latch_rf_wr_sched: arbitrated, registered write port plus read bypass and sleep/drain for a latch RF
module latch_rf_wr_sched
  import latch_rf_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  parameter  int CNTW  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  latch_rf_wr_sched_if.slave   req,
  output logic [DEPTH-1:0]     wr_row_en,
  output logic [WIDTH-1:0]     wr_data,
  input  logic [AW-1:0]        rd_addr,
  input  logic [WIDTH-1:0]     rd_data_arr,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 sleep_req,
  output logic                 sleep_ack,
  output logic [CNTW-1:0]      wr_cnt
);
  state_t state, nxt;
  logic en, acc;
  logic [NREQ-1:0] grant;
  logic [AW-1:0] wa;
  logic [WIDTH-1:0] wd;
  always_comb begin
    nxt = state;
    en  = 1'b0;
    en  = state == RUN && !sleep_req;
    nxt = state == RUN   ? (sleep_req ? DRAIN : RUN) :
          state == DRAIN ? (|wr_row_en ? DRAIN : SLEEP) :
                           (sleep_req ? SLEEP : RUN);
  end
  latch_rf_rr_arb2 u_arb (
    .clk    (clk),
    .rst_b  (rst_b),
    .vld    (req.req_vld),
    .en     (en),
    .accept (acc),
    .grant  (grant)
  );
  assign acc         = |grant;
  assign req.req_rdy = grant;
  assign wa          = grant[1] ? req.req_addr[AW +: AW] : req.req_addr[0 +: AW];
  assign wd          = grant[1] ? req.req_data[WIDTH +: WIDTH] : req.req_data[0 +: WIDTH];
  assign rd_data     = wr_row_en[rd_addr] ? wr_data : rd_data_arr;
  // Row enable and data are staged so the array latches see them stable for a full cycle.
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state     <= RUN;
      wr_row_en <= '0;
      wr_data   <= '0;
      sleep_ack <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      state     <= nxt;
      sleep_ack <= nxt == SLEEP;
      wr_row_en <= acc ? DEPTH'(1) << wa : '0;
      if (acc) wr_data <= wd;
      if (|wr_row_en && !(&wr_cnt)) wr_cnt <= wr_cnt + CNTW'(1);
    end
endmodule

// File: tb/tb_latch_rf_wr_sched.sv
// tb_latch_rf_wr_sched: directed stimulus with a cycle-level reference model and literal spot checks
module tb_latch_rf_wr_sched;
  localparam int AW = 4;
  localparam int W  = 32;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0] rd_data_arr = '0;
  logic sleep_req = 1'b0;
  logic [15:0] row_en, row_en4;
  logic [W-1:0] wdata, wdata4, rdata, rdata4;
  logic ack, ack4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int total = 0;
  int bad = 0;
  latch_rf_wr_sched_if #(.AW(AW), .WIDTH(W)) ia ();
  latch_rf_wr_sched_if #(.AW(AW), .WIDTH(W)) ib ();
  assign ib.req_vld  = ia.req_vld;
  assign ib.req_addr = ia.req_addr;
  assign ib.req_data = ia.req_data;
  always #5 clk = ~clk;
  latch_rf_wr_sched #(.DEPTH(16), .WIDTH(W), .CNTW(16)) u_dut (
    .clk(clk), .rst_b(rst_b), .req(ia.slave), .wr_row_en(row_en), .wr_data(wdata),
    .rd_addr(rd_addr), .rd_data_arr(rd_data_arr), .rd_data(rdata),
    .sleep_req(sleep_req), .sleep_ack(ack), .wr_cnt(cnt));
  latch_rf_wr_sched #(.DEPTH(16), .WIDTH(W), .CNTW(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .req(ib.slave), .wr_row_en(row_en4), .wr_data(wdata4),
    .rd_addr(rd_addr), .rd_data_arr(rd_data_arr), .rd_data(rdata4),
    .sleep_req(sleep_req), .sleep_ack(ack4), .wr_cnt(cnt4));
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask
  // Reference model: mode 0=run 1=drain 2=sleep; pending write = what the array sees this cycle.
  int m_ptr, m_cnt, m_mode;
  bit m_pv, m_ack;
  logic [AW-1:0] m_addr;
  logic [W-1:0] m_data;
  function automatic logic [1:0] exp_rdy();
    if (m_mode != 0 || sleep_req) return 2'b00;
    if (ia.req_vld == 2'b11) return m_ptr == 1 ? 2'b10 : 2'b01;
    return ia.req_vld;
  endfunction
  function automatic int next_mode();
    if (m_mode == 0) return sleep_req ? 1 : 0;
    if (m_mode == 1) return m_pv ? 1 : 2;
    return sleep_req ? 2 : 0;
  endfunction
  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      m_ptr <= 0; m_cnt <= 0; m_mode <= 0; m_pv <= 0; m_ack <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_pv <= exp_rdy() != 2'b00;
      if (exp_rdy() != 2'b00) begin
        m_ptr  <= exp_rdy() == 2'b01 ? 1 : 0;
        m_addr <= ia.req_addr[(exp_rdy() == 2'b10 ? AW : 0) +: AW];
        m_data <= ia.req_data[(exp_rdy() == 2'b10 ? W : 0) +: W];
      end
      if (m_pv && m_cnt < 65535) m_cnt <= m_cnt + 1;
      m_mode <= next_mode();
      m_ack  <= next_mode() == 2;
    end
  always @(negedge clk)
    if (rst_b) begin
      chk("rdy", ia.req_rdy, exp_rdy());
      chk("rdy4", ib.req_rdy, exp_rdy());
      chk("row_en", row_en, m_pv ? 16'(1) << m_addr : 16'h0);
      chk("row_en4", row_en4, m_pv ? 16'(1) << m_addr : 16'h0);
      chk("wr_data", wdata, m_data);
      chk("wr_data4", wdata4, m_data);
      chk("rd_data", rdata, (m_pv && m_addr == rd_addr) ? m_data : rd_data_arr);
      chk("rd_data4", rdata4, (m_pv && m_addr == rd_addr) ? m_data : rd_data_arr);
      chk("sleep_ack", ack, m_ack);
      chk("sleep_ack4", ack4, m_ack);
      chk("wr_cnt", cnt, m_cnt);
      chk("wr_cnt4", cnt4, m_cnt > 15 ? 15 : m_cnt);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    ia.req_vld = 2'b00; ia.req_addr = '0; ia.req_data = '0;
    #2;
    chk("rst_row_en", row_en, 16'h0);
    chk("rst_wr_data", wdata, 32'h0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_cnt", cnt, 16'h0);
    ia.req_vld = 2'b11;
    #1 chk("rst_ptr", ia.req_rdy, 2'b01);
    ia.req_vld = 2'b00;
    @(posedge clk); @(posedge clk); #1 rst_b = 1'b1;
    // single write from requester 0
    ia.req_vld = 2'b01; ia.req_addr = {4'd0, 4'd3}; ia.req_data = {32'h0, 32'hDEADBEEF};
    #2 chk("t1_rdy", ia.req_rdy, 2'b01);
    tick(); ia.req_vld = 2'b00;
    #2 chk("t1_en", row_en, 16'h0008);
    chk("t1_data", wdata, 32'hDEADBEEF);
    tick();
    #2 chk("t1_idle", row_en, 16'h0);
    chk("t1_cnt", cnt, 16'd1);
    ia.req_vld = 2'b10; ia.req_addr = {4'd7, 4'd0};
    tick(); ia.req_vld = 2'b00;
    tick();
    // both valid: alternating grants, no idle cycles
    ia.req_vld = 2'b11; ia.req_addr = {4'd2, 4'd1}; ia.req_data = {32'h22222222, 32'h11111111};
    for (int k = 0; k < 4; k++) begin
      #2 chk("t2_rdy", ia.req_rdy, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) chk("t2_en", row_en, (k % 2) ? 16'h0002 : 16'h0004);
      tick();
    end
    ia.req_vld = 2'b00;
    #2 chk("t2_last", row_en, 16'h0004);
    chk("t2_data", wdata, 32'h22222222);
    tick();
    // read bypass
    ia.req_vld = 2'b01; ia.req_addr = {4'd0, 4'd5}; ia.req_data = {32'h0, 32'h12345678};
    tick(); ia.req_vld = 2'b00; rd_addr = 4'd5; rd_data_arr = 32'h0;
    #2 chk("t3_bypass", rdata, 32'h12345678);
    tick(); rd_data_arr = 32'hAAAA5555;
    #2 chk("t3_array", rdata, 32'hAAAA5555);
    // sleep right behind an accepted write
    tick();
    ia.req_vld = 2'b01; ia.req_addr = {4'd0, 4'd9}; ia.req_data = {32'h0, 32'h99};
    #2 chk("t4_rdy0", ia.req_rdy, 2'b01);
    tick(); sleep_req = 1'b1;
    #2 chk("t4_rdy1", ia.req_rdy, 2'b00);
    chk("t4_pulse", row_en, 16'h0200);
    tick();
    #2 chk("t4_drain_en", row_en, 16'h0);
    chk("t4_drain_ack", ack, 1'b0);
    tick();
    #2 chk("t4_ack", ack, 1'b1);
    chk("t4_rdy_sleep", ia.req_rdy, 2'b00);
    tick();
    #2 chk("t4_ack_hold", ack, 1'b1);
    sleep_req = 1'b0;
    tick();
    #2 chk("t4_wake_ack", ack, 1'b0);
    chk("t4_wake_rdy", ia.req_rdy, 2'b01);
    ia.req_vld = 2'b00;
    // sleep_req dropped during drain still passes through sleep
    tick(); sleep_req = 1'b1;
    tick(); sleep_req = 1'b0;
    #2 chk("dr_ack0", ack, 1'b0);
    tick();
    #2 chk("dr_ack1", ack, 1'b1);
    tick();
    #2 chk("dr_ack2", ack, 1'b0);
    // async reset while a write is on the array
    ia.req_vld = 2'b01; ia.req_addr = {4'd6, 4'd4}; ia.req_data = {32'h66, 32'h44};
    tick(); ia.req_vld = 2'b11;
    #2 chk("t5_en", row_en, 16'h0010);
    rst_b = 1'b0;
    #1 chk("t5_row_en", row_en, 16'h0);
    chk("t5_data", wdata, 32'h0);
    chk("t5_cnt", cnt, 16'h0);
    chk("t5_ack", ack, 1'b0);
    chk("t5_ptr", ia.req_rdy, 2'b01);
    ia.req_vld = 2'b00;
    @(posedge clk); #1 rst_b = 1'b1;
    // saturation on the narrow counter
    for (int i = 0; i < 20; i++) begin
      ia.req_vld = 2'b01; ia.req_addr = {4'd0, 4'(i)}; ia.req_data = {32'h0, 32'(i)};
      tick();
    end
    ia.req_vld = 2'b00;
    tick(); tick();
    #2 chk("t6_cnt", cnt, 16'd20);
    chk("t6_cnt4", cnt4, 4'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
